// File: rtl/comp_mac.sv
// -----------------------------------------------------------------------------
// comp_mac
//   Pipelined unsigned multiplier with a framed accumulator.
//
//   Stage 1 : captures operands and a valid bit when ena is high.
//   Stage 2 : registers the full-width product into o_param, pulses dv.
//   Stage 3 : accumulates stage-2 products into frames of P_ACC_LEN
//             products. It publishes each completed frame sum on o_param_2
//             with a one-cycle acc_dv pulse. The sum saturates when
//             P_SAT=1 and wraps when P_SAT=0.
//
//   Latency : ena in cycle c -> dv in c+2; last ena of a frame -> acc_dv c+3.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   i_param    in   [P_SIZE-1:0]    operand A (unsigned)
//   i_param_2  in   [P_SIZE-1:0]    operand B (unsigned)
//   ena        in   operand-valid qualifier
//   clr        in   synchronous frame abort
//   o_param    out  [2*P_SIZE-1:0]  registered product
//   o_param_2  out  [2*P_SIZE-1:0]  registered frame sum
//   dv         out  product-valid pulse
//   acc_dv     out  frame-sum-valid pulse
//   sat        out  frame sum clamped (qualified by acc_dv, held afterwards)
// -----------------------------------------------------------------------------
module comp_mac #(
  parameter int P_SIZE    = 12,
  parameter int P_ACC_LEN = 8,
  parameter int P_SAT     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [P_SIZE-1:0]     i_param,
  input  logic [P_SIZE-1:0]     i_param_2,
  input  logic                  ena,
  input  logic                  clr,
  output logic [2*P_SIZE-1:0]   o_param,
  output logic [2*P_SIZE-1:0]   o_param_2,
  output logic                  dv,
  output logic                  acc_dv,
  output logic                  sat
);

  localparam int OW = 2 * P_SIZE;
  localparam int CW = $clog2(P_ACC_LEN);
  localparam int AW = OW + CW;
  localparam bit SAT_EN = (P_SAT != 0);
  localparam logic [CW-1:0] CNT_LAST = CW'(P_ACC_LEN - 1);

  // stage 1
  logic [P_SIZE-1:0] s1_a;
  logic [P_SIZE-1:0] s1_b;
  logic              s1_vld;

  // stage 2 sideband: product belongs to the current frame
  logic              s2_inc;

  // stage 3
  logic [AW-1:0]     acc;
  logic [CW-1:0]     cnt;

  logic [OW-1:0]     prod;
  logic [AW-1:0]     acc_sum;
  logic              frame_last;
  logic              overflow;

  assign prod       = OW'(s1_a) * OW'(s1_b);
  // First product of a frame loads rather than adds, so the accumulator
  // needs no explicit clear between frames.
  assign acc_sum    = ((cnt == '0) ? '0 : acc) + AW'(o_param);
  assign frame_last = (cnt == CNT_LAST);
  assign overflow   = |acc_sum[AW-1:OW];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_a   <= '0;
      s1_b   <= '0;
      s1_vld <= 1'b0;
    end else begin
      s1_vld <= ena;
      if (ena) begin
        s1_a <= i_param;
        s1_b <= i_param_2;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_param <= '0;
      dv      <= 1'b0;
      s2_inc  <= 1'b0;
    end else begin
      dv <= s1_vld;
      // A product landing here on a clr edge still goes out on o_param,
      // but it is tagged so the restarted frame does not pick it up.
      s2_inc <= s1_vld & ~clr;
      if (s1_vld) begin
        o_param <= prod;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      cnt       <= '0;
      o_param_2 <= '0;
      acc_dv    <= 1'b0;
      sat       <= 1'b0;
    end else begin
      acc_dv <= 1'b0;
      if (clr) begin
        acc <= '0;
        cnt <= '0;
      end else if (dv && s2_inc) begin
        if (frame_last) begin
          cnt    <= '0;
          acc    <= '0;
          acc_dv <= 1'b1;
          if (SAT_EN && overflow) begin
            o_param_2 <= '1;
            sat       <= 1'b1;
          end else begin
            o_param_2 <= acc_sum[OW-1:0];
            sat       <= 1'b0;
          end
        end else begin
          cnt <= cnt + CW'(1);
          acc <= acc_sum;
        end
      end
    end
  end

endmodule

// File: tb/tb_comp_mac.sv
module tb_comp_mac;

  localparam int W  = 12;
  localparam int OW = 2 * W;

  typedef struct {
    int             cyc;
    logic [OW-1:0]  val;
    logic           s;
  } exp_t;

  logic          clk;
  logic          rst;
  logic [W-1:0]  i_param;
  logic [W-1:0]  i_param_2;
  logic          ena;
  logic          clr;

  logic [OW-1:0] o_param_s, o_param_2_s, o_param_w, o_param_2_w;
  logic          dv_s, acc_dv_s, sat_s, dv_w, acc_dv_w, sat_w;

  comp_mac #(.P_SIZE(W), .P_ACC_LEN(4), .P_SAT(1)) u_dut_sat (
    .clk(clk), .rst(rst), .i_param(i_param), .i_param_2(i_param_2),
    .ena(ena), .clr(clr), .o_param(o_param_s), .o_param_2(o_param_2_s),
    .dv(dv_s), .acc_dv(acc_dv_s), .sat(sat_s)
  );

  comp_mac #(.P_SIZE(W), .P_ACC_LEN(4), .P_SAT(0)) u_dut_wrap (
    .clk(clk), .rst(rst), .i_param(i_param), .i_param_2(i_param_2),
    .ena(ena), .clr(clr), .o_param(o_param_w), .o_param_2(o_param_2_w),
    .dv(dv_w), .acc_dv(acc_dv_w), .sat(sat_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t prod_q[$];
  exp_t acc_q_s[$];
  exp_t acc_q_w[$];

  logic [OW-1:0] last_prod   = '0;
  logic [OW-1:0] last_acc_s  = '0;
  logic [OW-1:0] last_acc_w  = '0;
  logic          last_sat_s  = 1'b0;
  logic          last_sat_w  = 1'b0;
  int            last_op     = 0;

  task automatic chk(input string name, input longint act, input longint req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (dv_s) begin
        if (prod_q.size() == 0) begin
          chk("dv_unexpected", 1, 0);
        end else begin
          e = prod_q.pop_front();
          chk("dv_cycle", cyc, e.cyc);
          chk("o_param_sat_inst", o_param_s, e.val);
          chk("dv_wrap_inst", dv_w, 1);
          chk("o_param_wrap_inst", o_param_w, e.val);
          last_prod = e.val;
        end
      end else begin
        chk("dv_wrap_idle", dv_w, 0);
        chk("o_param_hold", o_param_s, last_prod);
        chk("o_param_hold_wrap", o_param_w, last_prod);
      end

      if (acc_dv_s) begin
        if (acc_q_s.size() == 0) begin
          chk("acc_dv_unexpected_sat", 1, 0);
        end else begin
          e = acc_q_s.pop_front();
          chk("acc_dv_cycle_sat", cyc, e.cyc);
          chk("o_param_2_sat", o_param_2_s, e.val);
          chk("sat_flag_sat", sat_s, e.s);
          last_acc_s = e.val;
          last_sat_s = e.s;
        end
      end else begin
        chk("o_param_2_hold_sat", o_param_2_s, last_acc_s);
        chk("sat_hold_sat", sat_s, last_sat_s);
      end

      if (acc_dv_w) begin
        if (acc_q_w.size() == 0) begin
          chk("acc_dv_unexpected_wrap", 1, 0);
        end else begin
          e = acc_q_w.pop_front();
          chk("acc_dv_cycle_wrap", cyc, e.cyc);
          chk("o_param_2_wrap", o_param_2_w, e.val);
          chk("sat_flag_wrap", sat_w, e.s);
          last_acc_w = e.val;
          last_sat_w = e.s;
        end
      end else begin
        chk("o_param_2_hold_wrap", o_param_2_w, last_acc_w);
        chk("sat_hold_wrap", sat_w, last_sat_w);
      end
    end
  end

  task automatic op(input int a, input int b, input logic c = 1'b0);
    exp_t e;
    i_param   = W'(a);
    i_param_2 = W'(b);
    ena       = 1'b1;
    clr       = c;
    e.cyc = cyc + 2;
    e.val = OW'(a * b);
    e.s   = 1'b0;
    prod_q.push_back(e);
    last_op = cyc;
    @(posedge clk);
    #1;
    ena = 1'b0;
    clr = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clr_cycle();
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
  endtask

  task automatic exp_acc(input int v_s, input logic s_s, input int v_w, input logic s_w);
    exp_t e;
    e.cyc = last_op + 3;
    e.val = OW'(v_s);
    e.s   = s_s;
    acc_q_s.push_back(e);
    e.val = OW'(v_w);
    e.s   = s_w;
    acc_q_w.push_back(e);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_o_param"},   o_param_s,   0);
    chk({tag, "_o_param_2"}, o_param_2_s, 0);
    chk({tag, "_dv"},        dv_s,        0);
    chk({tag, "_acc_dv"},    acc_dv_s,    0);
    chk({tag, "_sat"},       sat_s,       0);
    chk({tag, "_o_param_w"}, o_param_w,   0);
    chk({tag, "_o_param_2_w"}, o_param_2_w, 0);
    chk({tag, "_sat_w"},     sat_w,       0);
  endtask

  initial begin
    rst       = 1'b1;
    ena       = 1'b0;
    clr       = 1'b0;
    i_param   = '0;
    i_param_2 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset_init");
    rst = 1'b0;
    idle(2);

    // single product 3*5; then abort the partial frame so no acc_dv follows
    op(3, 5);
    idle(3);
    clr_cycle();
    idle(2);

    // full frame, back-to-back
    op(1, 1); op(2, 2); op(3, 3); op(4, 4);
    exp_acc(30, 1'b0, 30, 1'b0);
    idle(5);

    // saturation / wrap
    repeat (4) op(4095, 4095);
    exp_acc(16777215, 1'b1, 16744452, 1'b0);
    idle(5);

    // frame spanning idle gaps: 2 + 12 + 30 + 56
    op(1, 2); idle(2); op(3, 4); idle(1); op(5, 6); op(7, 8);
    exp_acc(100, 1'b0, 100, 1'b0);
    idle(5);

    // clr mid-frame, two products discarded
    op(10, 10); op(10, 10);
    clr_cycle();
    repeat (4) op(2, 2);
    exp_acc(16, 1'b0, 16, 1'b0);
    idle(5);

    // clr on the edge a product reaches stage 2: that product is excluded
    op(10, 10);
    op(2, 2, 1'b1);
    repeat (3) op(2, 2);
    exp_acc(16, 1'b0, 16, 1'b0);
    idle(5);

    // reset mid-frame with operations in flight
    repeat (3) op(5, 5);
    #2;
    rst = 1'b1;
    prod_q.delete();
    acc_q_s.delete();
    acc_q_w.delete();
    last_prod  = '0;
    last_acc_s = '0;
    last_acc_w = '0;
    last_sat_s = 1'b0;
    last_sat_w = 1'b0;
    #1;
    chk_zero("reset_async");
    @(posedge clk);
    #1;
    chk_zero("reset_held");
    rst = 1'b0;
    repeat (4) op(1, 1);
    exp_acc(4, 1'b0, 4, 1'b0);
    idle(8);

    chk("prod_q_drained", prod_q.size(), 0);
    chk("acc_q_sat_drained", acc_q_s.size(), 0);
    chk("acc_q_wrap_drained", acc_q_w.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/comp_mac.md
COMP_MAC -- requirements
Module: comp_mac

Interface
REQ-001 SHALL have parameter P_SIZE, default 12, operand width in bits (>=2).
REQ-002 SHALL have parameter P_ACC_LEN, default 8, products per accumulation frame (>=2).
REQ-003 SHALL have parameter P_SAT, default 1, 1 = saturating accumulator, 0 = wrap-around accumulator.
REQ-004 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port i_param  input  P_SIZE  operand A, unsigned.
REQ-007 SHALL have port i_param_2  input  P_SIZE  operand B, unsigned.
REQ-008 SHALL have port ena  input  1  operand-valid qualifier, sampled each rising edge.
REQ-009 SHALL have port clr  input  1  synchronous frame abort: clears accumulator and frame counter.
REQ-010 SHALL have port o_param  output  2*P_SIZE  registered product A*B.
REQ-011 SHALL have port o_param_2  output  2*P_SIZE  registered frame sum.
REQ-012 SHALL have port dv  output  1  one-cycle pulse, o_param valid.
REQ-013 SHALL have port acc_dv  output  1  one-cycle pulse, o_param_2 holds a completed frame sum.
REQ-014 SHALL have port sat  output  1  frame sum clamped; valid with acc_dv.

Function
REQ-015 Stage 1 SHALL register i_param, i_param_2 and a valid bit on every edge where ena=1; valid bit 0 otherwise.
REQ-016 Stage 2 SHALL register the full-width product of stage-1 operands into o_param and assert dv one cycle when stage-1 valid=1; ena high in cycle c -> dv high in cycle c+2.
REQ-017 o_param SHALL hold its last value while dv=0.
REQ-018 Back-to-back ena (every cycle) SHALL be accepted with no bubbles; throughput one product per cycle.
REQ-019 A frame counter (0..P_ACC_LEN-1) SHALL advance on each stage-2 product; the first product of a frame loads the accumulator, later products add to it.
REQ-020 On the product taking the counter to P_ACC_LEN, the accumulator result SHALL be registered into o_param_2 and acc_dv asserted for one cycle (ena of the last operand in cycle c -> acc_dv in cycle c+3); counter returns to 0.
REQ-021 o_param_2 and sat SHALL hold until the next frame completes.
REQ-022 Internal accumulator SHALL be 2*P_SIZE + clog2(P_ACC_LEN) bits; with P_SAT=1 a sum exceeding 2^(2*P_SIZE)-1 SHALL output all-ones and sat=1; with P_SAT=0 output SHALL be the low 2*P_SIZE bits and sat=0.
REQ-023 clr=1 SHALL zero accumulator and counter on that edge; a product arriving at stage 2 on the same edge SHALL be excluded from the frame but still appear on o_param/dv.
REQ-024 clr SHALL not affect o_param_2, sat, or pipeline stages; no acc_dv for an aborted frame.
REQ-025 Gaps in ena SHALL not reset the frame; frames span any number of idle cycles.

Reset
REQ-026 rst=1 SHALL immediately clear o_param, o_param_2, dv, acc_dv, sat, accumulator, counter and all pipeline valid bits to 0.
REQ-027 Operations in flight at reset SHALL be discarded; no dv or acc_dv for them after rst deasserts.
REQ-028 First edge after rst deasserts SHALL accept ena normally.

Verification (P_SIZE=12, P_ACC_LEN=4)
REQ-029 Reset: assert rst mid-cycle -> all outputs 0 before next edge, held while rst=1.
REQ-030 Single product: ena one cycle with 3, 5 in cycle c -> dv=1 and o_param=15 in cycle c+2 only; o_param stays 15 afterwards.
REQ-031 Frame: ena cycles c..c+3 with (1,1),(2,2),(3,3),(4,4) -> dv c+2..c+5 with 1,4,9,16; acc_dv in c+6 with o_param_2=30, sat=0.
REQ-032 Saturation: four (4095,4095) -> P_SAT=1: o_param_2=16777215, sat=1; P_SAT=0: o_param_2=16744452, sat=0.
REQ-033 clr mid-frame: two products of 10*10, clr, then four of (2,2) -> single acc_dv with o_param_2=16; no acc_dv for aborted frame.
REQ-034 Reset mid-frame: three products, rst one cycle, four (1,1) -> no dv/acc_dv from pre-reset ops; acc_dv with o_param_2=4.
